// File: rtl/gpp_pkg.sv
// Shared encodings for the gpp_core processor: opcodes, FSM state codes and
// instruction field positions.
package gpp_pkg;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LDI   = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_SEQ   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JZ    = 4'd10;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_FWAIT  = 4'd2;
   localparam logic [3:0] S_EXEC   = 4'd3;
   localparam logic [3:0] S_LWAIT  = 4'd4;
   localparam logic [3:0] S_HALTED = 4'd5;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RN_HI  = 11;
   localparam int RN_LO  = 8;
   localparam int RM_HI  = 7;
   localparam int RM_LO  = 4;
   localparam int RO_HI  = 3;
   localparam int RO_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Register-to-register ALU opcodes that write back to Ro.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SEQ);
   endfunction

endpackage

// File: rtl/gpp_regfile.sv
// Register file: one write port, two operand read ports and a debug read port.
// Indices at or above NREG read as zero and ignore writes.
module gpp_regfile
   import gpp_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          we,
   input  logic [3:0]    waddr,
   input  logic [DW-1:0] wdata,
   input  logic [3:0]    ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [3:0]    rb_addr,
   output logic [DW-1:0] rb_data,
   input  logic [3:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];

   // Next-state and read muxes; only implemented indices ever match.
   always_comb begin
      ra_data  = '0;
      rb_data  = '0;
      dbg_data = '0;
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = (we && (waddr == 4'(i))) ? wdata : regs_q[i];
         ra_data   = (ra_addr  == 4'(i)) ? regs_q[i] : ra_data;
         rb_data   = (rb_addr  == 4'(i)) ? regs_q[i] : rb_data;
         dbg_data  = (dbg_addr == 4'(i)) ? regs_q[i] : dbg_data;
      end
   end

   // Register storage with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/gpp_core.sv
// Multicycle general-purpose processor core: fetch/decode/execute FSM and ALU
// in front of an external single-port synchronous RAM.
module gpp_core
   import gpp_pkg::*;
#(
   parameter int DW   = 16,
   parameter int AW   = 8,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          start,
   output logic          busy,
   output logic          halted,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] pc,
   output logic [3:0]    state,
   input  logic [3:0]    dbg_sel,
   output logic [DW-1:0] dbg_data
);

   logic [3:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [15:0]   ir_q, ir_d;

   logic [3:0]    op_s, rn_s, rm_s, ro_s;
   logic [7:0]    imm8_s;
   logic [AW-1:0] imm_addr_s;
   logic [DW-1:0] rn_data_s, rm_data_s, alu_s;
   logic          rf_we_s;
   logic [3:0]    rf_waddr_s;
   logic [DW-1:0] rf_wdata_s;

   assign op_s       = ir_q[OP_HI:OP_LO];
   assign rn_s       = ir_q[RN_HI:RN_LO];
   assign rm_s       = ir_q[RM_HI:RM_LO];
   assign ro_s       = ir_q[RO_HI:RO_LO];
   assign imm8_s     = ir_q[IMM_HI:IMM_LO];
   assign imm_addr_s = AW'(imm8_s);

   gpp_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
      .clk      (clk),
      .rst_     (rst_),
      .we       (rf_we_s),
      .waddr    (rf_waddr_s),
      .wdata    (rf_wdata_s),
      .ra_addr  (rn_s),
      .ra_data  (rn_data_s),
      .rb_addr  (rm_s),
      .rb_data  (rm_data_s),
      .dbg_addr (dbg_sel),
      .dbg_data (dbg_data)
   );

   // ALU: modulo-2^DW arithmetic, no flags, unsigned compare.
   always_comb begin
      case (op_s)
         OP_ADD:  alu_s = rn_data_s + rm_data_s;
         OP_SUB:  alu_s = rn_data_s - rm_data_s;
         OP_AND:  alu_s = rn_data_s & rm_data_s;
         OP_OR:   alu_s = rn_data_s | rm_data_s;
         OP_SLT:  alu_s = DW'(rn_data_s < rm_data_s);
         OP_SEQ:  alu_s = DW'(rn_data_s == rm_data_s);
         default: alu_s = '0;
      endcase
   end

   // Sequencer: next state, pc/IR updates and register write-back.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      rf_we_s    = 1'b0;
      rf_waddr_s = ro_s;
      rf_wdata_s = alu_s;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: state_d = S_FWAIT;
         S_FWAIT: begin
            ir_d    = mem_rdata[15:0];
            pc_d    = pc_q + AW'(1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op_s)
               OP_LOAD:  state_d = S_LWAIT;
               OP_STORE: state_d = S_FETCH;
               OP_LDI: begin
                  rf_we_s    = 1'b1;
                  rf_waddr_s = rn_s;
                  rf_wdata_s = DW'(imm8_s);
               end
               OP_JMP:   pc_d = imm_addr_s;
               OP_JZ:    pc_d = (rn_data_s == '0) ? imm_addr_s : pc_q;
               OP_HALT:  state_d = S_HALTED;
               default:  rf_we_s = is_alu_op(op_s);
            endcase
         end
         S_LWAIT: begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rn_s;
            rf_wdata_s = mem_rdata;
            state_d    = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory interface is a pure decode of state, pc and IR.
   always_comb begin
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         S_FETCH: begin
            mem_addr = pc_q;
            mem_re   = 1'b1;
         end
         S_EXEC: begin
            if (op_s == OP_LOAD) begin
               mem_addr = imm_addr_s;
               mem_re   = 1'b1;
            end else if (op_s == OP_STORE) begin
               mem_addr  = imm_addr_s;
               mem_we    = 1'b1;
               mem_wdata = rn_data_s;
            end else begin
               mem_re = 1'b0;
            end
         end
         default: mem_re = 1'b0;
      endcase
   end

   // Architectural state flops with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted = (state_q == S_HALTED);
   assign pc     = pc_q;
   assign state  = state_q;

endmodule

// File: tb/tb_gpp_core.sv
// Directed bench for gpp_core: table-driven ALU programs plus hand-written
// sequences for memory, branches, mid-instruction reset and a wide variant.
module tb_gpp_core;

   logic        clk = 1'b0;
   logic        rst_;
   logic        start;
   logic        busy, halted, mem_re, mem_we;
   logic [7:0]  mem_addr, pc;
   logic [15:0] mem_wdata, mem_rdata, dbg_data;
   logic [3:0]  state, dbg_sel;

   logic        start2;
   logic        busy2, halted2, mem_re2, mem_we2;
   logic [9:0]  mem_addr2, pc2;
   logic [31:0] mem_wdata2, mem_rdata2, dbg_data2;
   logic [3:0]  state2, dbg_sel2;

   logic [15:0] mem [256];
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic [15:0] prog [16];

   int total = 0;
   int bad   = 0;
   int we_cnt, lw_cnt, both_cnt, cyc;
   logic [7:0]  we_addr;
   logic [15:0] we_data;

   always #5 clk = ~clk;

   gpp_core #(.DW(16), .AW(8), .NREG(16)) dut (
      .clk(clk), .rst_(rst_), .start(start), .busy(busy), .halted(halted),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc(pc), .state(state),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   gpp_core #(.DW(32), .AW(10), .NREG(8)) dut2 (
      .clk(clk), .rst_(rst_), .start(start2), .busy(busy2), .halted(halted2),
      .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .pc(pc2), .state(state2),
      .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
   );

   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // Wide core's ROM: two LDIs, a SUB, then NOPs everywhere; upper half is junk.
   function automatic logic [15:0] rom2(input logic [9:0] a);
      case (a)
         10'd0:   return 16'h2977;
         10'd1:   return 16'h2133;
         10'd2:   return 16'h4012;
         default: return 16'hB000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_re2) mem_rdata2 <= {16'hDEAD, rom2(mem_addr2)};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reg(input string name, input logic [3:0] sel, input logic [31:0] exp);
      dbg_sel = sel;
      #1;
      chk(name, {16'h0, dbg_data}, exp);
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      @(posedge clk); #1;
      rst_ = 1'b1;
   endtask

   task automatic load_prog(input int n);
      for (int i = 0; i < n; i++) begin
         load_en = 1'b1; load_addr = 8'(i); load_data = prog[i];
         @(posedge clk); #1;
      end
      load_en = 1'b0;
   endtask

   task automatic run_prog(input int max_cyc);
      logic done;
      done = 1'b0; cyc = 0; we_cnt = 0; lw_cnt = 0; both_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
         if (state == 4'd4) lw_cnt++;
         if (mem_re && mem_we) both_cnt++;
         if (halted) done = 1'b1;
      end
      chk("halt_reached", {31'h0, done}, 32'h1);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic seen;
      vecs[0]  = '{4'd3,  8'h05, 8'h03, 16'h0008};
      vecs[1]  = '{4'd4,  8'h00, 8'h01, 16'hFFFF};
      vecs[2]  = '{4'd4,  8'h09, 8'h04, 16'h0005};
      vecs[3]  = '{4'd5,  8'hF0, 8'h3C, 16'h0030};
      vecs[4]  = '{4'd6,  8'hF0, 8'h0F, 16'h00FF};
      vecs[5]  = '{4'd7,  8'h00, 8'h01, 16'h0001};
      vecs[6]  = '{4'd7,  8'h01, 8'h00, 16'h0000};
      vecs[7]  = '{4'd7,  8'h05, 8'h05, 16'h0000};
      vecs[8]  = '{4'd8,  8'h07, 8'h07, 16'h0001};
      vecs[9]  = '{4'd8,  8'h07, 8'h08, 16'h0000};
      vecs[10] = '{4'd3,  8'hFF, 8'hFF, 16'h01FE};
      vecs[11] = '{4'd11, 8'h12, 8'h34, 16'h0000};

      rst_ = 1'b0; start = 1'b0; start2 = 1'b0; dbg_sel = 4'd0; dbg_sel2 = 4'd0;
      load_en = 1'b0; load_addr = 8'd0; load_data = 16'd0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_state", {28'h0, state}, 32'h0);
      chk("rst_pc", {24'h0, pc}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      chk("rst_strobes", {30'h0, mem_re, mem_we}, 32'h0);
      chk("rst_addr", {24'h0, mem_addr}, 32'h0);
      chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
      for (int i = 0; i < 16; i++) chk_reg("rst_reg", 4'(i), 32'h0);
      rst_ = 1'b1;

      // LDI R1,a; LDI R2,b; op R1,R2->R3; HALT
      for (int v = 0; v < 12; v++) begin
         do_reset();
         prog[0] = {4'h2, 4'h1, vecs[v].a};
         prog[1] = {4'h2, 4'h2, vecs[v].b};
         prog[2] = {vecs[v].op, 4'h1, 4'h2, 4'h3};
         prog[3] = 16'hF000;
         load_prog(4);
         run_prog(40);
         chk("vec_cycles", 32'(cyc), 32'd12);
         chk("vec_pc", {24'h0, pc}, 32'h4);
         chk_reg("vec_r3", 4'd3, {16'h0, vecs[v].exp});
      end

      // STORE / LOAD round trip through RAM.
      do_reset();
      prog[0] = 16'h21A5; prog[1] = 16'h1140; prog[2] = 16'h0440; prog[3] = 16'hF000;
      load_prog(4);
      run_prog(40);
      chk("st_we_cnt", 32'(we_cnt), 32'd1);
      chk("st_addr", {24'h0, we_addr}, 32'h40);
      chk("st_data", {16'h0, we_data}, 32'hA5);
      chk("ld_lwait", 32'(lw_cnt), 32'd1);
      chk("ld_cycles", 32'(cyc), 32'd13);
      chk("re_we_excl", 32'(both_cnt), 32'd0);
      chk_reg("ld_r4", 4'd4, 32'hA5);

      // JZ taken, then restart from HALTED with JZ not taken.
      do_reset();
      prog[0] = 16'h2500; prog[1] = 16'hA510; prog[2] = 16'h2699;
      load_prog(3);
      load_en = 1'b1; load_addr = 8'h10; load_data = 16'hF000;
      @(posedge clk); #1 load_en = 1'b0;
      run_prog(40);
      chk("jz_taken_pc", {24'h0, pc}, 32'h11);
      chk_reg("jz_skip_r6", 4'd6, 32'h0);
      prog[0] = 16'h2501; prog[1] = 16'hA510; prog[2] = 16'hF000;
      load_prog(3);
      run_prog(40);
      chk("jz_fall_pc", {24'h0, pc}, 32'h3);

      // Counting loop closed by JMP 0x00, exited by JZ.
      do_reset();
      prog[0] = 16'h2101; prog[1] = 16'h3212; prog[2] = 16'h2402; prog[3] = 16'h4245;
      prog[4] = 16'hA507; prog[5] = 16'h9000; prog[6] = 16'h26EE; prog[7] = 16'hF000;
      load_prog(8);
      run_prog(80);
      chk("loop_cycles", 32'(cyc), 32'd36);
      chk("loop_pc", {24'h0, pc}, 32'h8);
      chk_reg("loop_r2", 4'd2, 32'h2);
      chk_reg("loop_r6", 4'd6, 32'h0);

      // Reset while a LOAD waits for data, then restart.
      do_reset();
      prog[0] = 16'h215A; prog[1] = 16'h0440; prog[2] = 16'hF000;
      load_prog(3);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (state == 4'd4) seen = 1'b1;
      end
      chk("lwait_seen", {31'h0, seen}, 32'h1);
      rst_ = 1'b0;
      @(posedge clk); #1;
      chk("mid_state", {28'h0, state}, 32'h0);
      chk("mid_pc", {24'h0, pc}, 32'h0);
      chk("mid_strobes", {30'h0, mem_re, mem_we}, 32'h0);
      chk("mid_busy", {31'h0, busy}, 32'h0);
      chk_reg("mid_r1", 4'd1, 32'h0);
      rst_ = 1'b1;
      run_prog(40);
      chk("restart_cycles", 32'(cyc), 32'd10);
      chk("restart_pc", {24'h0, pc}, 32'h3);
      chk_reg("restart_r1", 4'd1, 32'h5A);
      chk_reg("restart_r4", 4'd4, 32'hA5);

      // Wide variant: pc wraps 0x3FF -> 0, R9 is beyond NREG.
      start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(posedge clk); #1;
         if (pc2 == 10'h3FF) seen = 1'b1;
      end
      chk("w_reach_3ff", {31'h0, seen}, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(posedge clk); #1;
         if (pc2 == 10'h000) seen = 1'b1;
      end
      chk("w_pc_wrap", {31'h0, seen}, 32'h1);
      chk("w_busy", {31'h0, busy2}, 32'h1);
      dbg_sel2 = 4'd9; #1;
      chk("w_r9_dropped", dbg_data2, 32'h0);
      dbg_sel2 = 4'd1; #1;
      chk("w_r1", dbg_data2, 32'h33);
      dbg_sel2 = 4'd2; #1;
      chk("w_sub_wrap", dbg_data2, 32'hFFFFFFCD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
